if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage CPU. Holds the program counter, drives the synchronous instruction memory and loads the IF_ID buffer with `instr`, `pc_plus_4` and `interrupt`. It redirects on `branch_sel`/`branch_pc` from the decode stage, stalls on hazard requests and injects external interrupts through a small state machine.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `INT_VECTOR`, 32'h0000_0100, ISR entry address
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `stall` input 1: hazard unit; hold PC and IF_ID contents
- `branch_sel` input 1: decode-stage redirect request
- `branch_pc` input 32: redirect target
- `returni` input 1: decode stage is processing return-from-interrupt
- `irq` input 1: external interrupt, level-sensitive
- `imem_addr` output 32: fetch address (equals PC)
- `imem_en` output 1: read enable; memory holds `imem_rdata` when low
- `imem_rdata` input 32: instruction, valid one cycle after address with `imem_en`
- `instr` output 32: to IF_ID; `imem_rdata` gated to 32'h0 when `valid`=0
- `pc_plus_4` output 32: to IF_ID; fetch address + 4, or return address when `interrupt`=1
- `interrupt` output 1: to IF_ID; marks first ISR instruction
- `valid` output 1: to IF_ID; 0 = bubble

## Operation
- `pc` register; `imem_addr = pc`; `imem_en = ~stall`.
- Registered side outputs (`pc_plus_4`, `interrupt`, `valid`) update only when `stall`=0, tagging the address issued that cycle; the instruction word arrives from memory in the same cycle they appear.
- Next-PC priority (evaluated only when `stall`=0): 1. `branch_sel` -> `branch_pc`, issued fetch squashed (`valid`<=0); 2. interrupt take -> `INT_VECTOR`, issued fetch squashed; 3. `pc + 4` (32-bit wrap, 32'hFFFF_FFFC -> 0).
- FSM states: RUN, TAKE, ISR.
  - RUN -> TAKE: `irq`=1, `stall`=0, `branch_sel`=0. Captures `epc <= pc`, sets `pc <= INT_VECTOR`, squashes current fetch.
  - TAKE -> ISR: first non-stalled cycle; fetch of `INT_VECTOR` tagged `interrupt`=1, `pc_plus_4 = epc`, `valid`=1.
  - TAKE + `branch_sel`: branch wins; stays in TAKE and re-targets `INT_VECTOR` next cycle.
  - ISR -> RUN: `returni`=1 and `stall`=0. `irq` is ignored (masked) while in TAKE/ISR.
- `irq` while `branch_sel`=1 is deferred, never lost while level is held.
- `stall` and `branch_sel` together: stall wins; the branch must be re-presented.

## Timing
- Reset values: `pc`=`RESET_PC`, state RUN, `epc`=0, `valid`=0, `interrupt`=0, `pc_plus_4`=0. `imem_en`=1 follows combinationally.
- First valid instruction appears one cycle after reset release.
- Fetch latency: 1 cycle from address to IF_ID.
- Branch penalty: 1 bubble. Interrupt entry: 1 bubble, then the ISR first instruction.
- Reset mid-TAKE/ISR: returns to RUN, mask cleared, `epc` discarded.
- During stall, every output and `imem_rdata` stays constant.

## Configuration
- `IF_STAGE_INT_EN` defined: TAKE/ISR FSM, `epc` and masking as described.
- Undefined: no FSM or `epc`. `irq` and `returni` are ignored, `interrupt` is tied 0, and `pc_plus_4` always equals fetch address + 4.

## Structure
- `cpu_pkg`: `fetch_state_t` enum (RUN, TAKE, ISR), default `RESET_PC`/`INT_VECTOR` constants, instruction width.
- Sub-module `irq_ctrl`: the FSM plus `epc`. Outputs take/tag/return-address signals to the PC logic. Compiled only under `IF_STAGE_INT_EN`.

## Test plan
- Reset release, no stall -> `imem_addr` 0,4,8; `valid`=1 from cycle 1 with `pc_plus_4` 4,8,12.
- At `pc`=0x10, `branch_sel`=1, `branch_pc`=0x40 -> next `valid`=0; following cycle `instr` from 0x40 with `pc_plus_4`=0x44.
- `stall` held 3 cycles at `pc`=0x20 -> `imem_en`=0 and all outputs frozen; resumes at 0x24 afterwards.
- `irq`=1 at `pc`=0x30 -> bubble, then `instr` from 0x100 with `interrupt`=1 and `pc_plus_4`=0x30; `irq` still high in ISR causes no retake until `returni`, after which the next `irq` is accepted.
- `irq` and `branch_sel` (target 0x80) in the same cycle -> branch to 0x80 first, then interrupt taken with `pc_plus_4`=0x80.
- `rst_n` asserted while in ISR -> `pc`=0, `valid`=0, `interrupt`=0; after release `irq` is accepted again.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: fetch FSM states, default fetch/ISR
// addresses, instruction width and the PC increment helper.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int XLEN    = 32;

  localparam logic [XLEN-1:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_INT_VECTOR = 32'h0000_0100;

  // RUN: normal fetch. TAKE: PC points at the ISR vector and the next
  // unstalled fetch is the first ISR instruction. ISR: interrupts masked
  // until return-from-interrupt.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TAKE = 2'd1,
    ISR  = 2'd2
  } fetch_state_t;

  // Sequential next-fetch address; wraps naturally at 32 bits.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/irq_ctrl.sv
// Interrupt entry/exit controller for the fetch stage: RUN/TAKE/ISR FSM
// plus the saved return address (epc). Compiled only with IF_STAGE_INT_EN.
module irq_ctrl
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_stall,
  input  logic            i_branch_sel,
  input  logic            i_irq,
  input  logic            i_returni,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_take,
  output logic            o_tag,
  output logic [XLEN-1:0] o_epc,
  output fetch_state_t    o_state
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_epc;
  logic            r_retake;
  logic            w_retake_nxt;
  logic            w_take;
  logic            w_tag;

  // Next-state and take/tag decode. o_take redirects the PC to the vector
  // and squashes the fetch issued this cycle; o_tag marks the fetch issued
  // this cycle as the first ISR instruction. A branch seen in TAKE moves
  // the PC away from the vector, so r_retake forces one more redirect.
  always_comb begin
    w_state_nxt  = r_state;
    w_retake_nxt = r_retake;
    w_take       = 1'b0;
    w_tag        = 1'b0;
    case (r_state)
      RUN: begin
        if (!i_stall && !i_branch_sel && i_irq) begin
          w_take      = 1'b1;
          w_state_nxt = TAKE;
        end
      end
      TAKE: begin
        if (!i_stall) begin
          if (i_branch_sel) begin
            w_retake_nxt = 1'b1;
          end else if (r_retake) begin
            w_take       = 1'b1;
            w_retake_nxt = 1'b0;
          end else begin
            w_tag       = 1'b1;
            w_state_nxt = ISR;
          end
        end
      end
      ISR: begin
        if (!i_stall && i_returni) begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt  = RUN;
        w_retake_nxt = 1'b0;
      end
    endcase
  end

  // State, retake flag and epc registers; epc captures the PC being
  // abandoned whenever the vector redirect happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_retake <= 1'b0;
      r_epc    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_retake <= w_retake_nxt;
      if (w_take) begin
        r_epc <= i_pc;
      end
    end
  end

  assign o_take  = w_take;
  assign o_tag   = w_tag;
  assign o_epc   = r_epc;
  assign o_state = r_state;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, synchronous instruction-memory
// drive and IF_ID outputs, with branch redirect and stall handling.
// Optional feature macro: IF_STAGE_INT_EN enables interrupt entry via
// irq_ctrl; without it irq/returni are ignored and interrupt is tied 0.
//
// IF_ID handshake: valid=1 means instr/pc_plus_4/interrupt describe a real
// fetched instruction; valid=0 is a bubble (instr forced to 0). There is no
// ready; the hazard unit holds everything with stall=1, during which no
// output changes and the memory read is disabled.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [XLEN-1:0] INT_VECTOR = DEF_INT_VECTOR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_sel,
  input  logic [XLEN-1:0]    branch_pc,
  input  logic               returni,
  input  logic               irq,
  output logic [XLEN-1:0]    imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    pc_plus_4,
  output logic               interrupt,
  output logic               valid
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus_4;
  logic            r_interrupt;
  logic            r_valid;

  logic [XLEN-1:0] w_pc_inc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_link;
  logic            w_take;
  logic            w_tag;

  assign w_pc_inc = pc_inc(r_pc);

`ifdef IF_STAGE_INT_EN
  logic [XLEN-1:0] w_epc;
  fetch_state_t    w_dbg_state_unused;

  irq_ctrl u_irq_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_stall      (stall),
    .i_branch_sel (branch_sel),
    .i_irq        (irq),
    .i_returni    (returni),
    .i_pc         (r_pc),
    .o_take       (w_take),
    .o_tag        (w_tag),
    .o_epc        (w_epc),
    .o_state      (w_dbg_state_unused)
  );

  // The first ISR instruction carries the interrupted PC as its link.
  assign w_link = w_tag ? w_epc : w_pc_inc;
`else
  logic w_unused_int;

  assign w_take       = 1'b0;
  assign w_tag        = 1'b0;
  assign w_link       = w_pc_inc;
  assign w_unused_int = irq ^ returni;
`endif

  // Next-PC select: branch beats interrupt redirect beats sequential.
  always_comb begin
    w_pc_nxt = r_pc;
    if (!stall) begin
      if (branch_sel) begin
        w_pc_nxt = branch_pc;
      end else if (w_take) begin
        w_pc_nxt = INT_VECTOR;
      end else begin
        w_pc_nxt = w_pc_inc;
      end
    end
  end

  // PC and IF_ID side registers; they tag the address issued this cycle,
  // whose instruction word arrives from memory alongside them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_pc_plus_4 <= '0;
      r_interrupt <= 1'b0;
      r_valid     <= 1'b0;
    end else if (!stall) begin
      r_pc        <= w_pc_nxt;
      r_pc_plus_4 <= w_link;
      r_interrupt <= w_tag;
      r_valid     <= !(branch_sel || w_take);
    end
  end

  assign imem_addr = r_pc;
  assign imem_en   = !stall;
  assign instr     = r_valid ? imem_rdata : '0;
  assign pc_plus_4 = r_pc_plus_4;
  assign interrupt = r_interrupt;
  assign valid     = r_valid;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: synchronous instruction-memory model, directed
// stimulus with expected IF_ID entries queued per driven cycle and checked
// one cycle later. Interrupt scenarios are selected with IF_STAGE_INT_EN.
module tb_if_stage;

  localparam int E_W = 98;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_sel = 1'b0;
  logic [31:0] branch_pc = '0;
  logic        returni = 1'b0;
  logic        irq = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] pc_plus_4;
  logic        interrupt;
  logic        valid;

  int n_checks = 0;
  int n_fail   = 0;
  int step_no  = 0;

  // {next imem_addr, valid, interrupt, pc_plus_4, instr}
  logic [E_W-1:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  if_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .branch_sel (branch_sel),
    .branch_pc  (branch_pc),
    .returni    (returni),
    .irq        (irq),
    .imem_addr  (imem_addr),
    .imem_en    (imem_en),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .pc_plus_4  (pc_plus_4),
    .interrupt  (interrupt),
    .valid      (valid)
  );

  // Distinct, address-derived instruction words.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Synchronous memory: holds its output while the read enable is low.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    logic [E_W-1:0] e;
    @(posedge clk);
    #1;
    step_no++;
    if (exp_q.size() == 0) begin
      check($sformatf("queue_empty@%0d", step_no), 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check($sformatf("valid@%0d", step_no),     {31'b0, valid},     {31'b0, e[65]});
    check($sformatf("interrupt@%0d", step_no), {31'b0, interrupt}, {31'b0, e[64]});
    check($sformatf("pc_plus_4@%0d", step_no), pc_plus_4,          e[63:32]);
    check($sformatf("instr@%0d", step_no),     instr,              e[31:0]);
    check($sformatf("imem_addr@%0d", step_no), imem_addr,          e[97:66]);
  endtask

  // Drive one cycle of inputs, queue the IF_ID entry it must produce
  // (ia = address whose instruction is expected, na = next fetch address).
  task automatic step(input logic s, input logic b, input logic [31:0] bpc,
                      input logic q, input logic r,
                      input logic v, input logic it, input logic [31:0] pp4,
                      input logic [31:0] ia, input logic [31:0] na);
    stall      = s;
    branch_sel = b;
    branch_pc  = bpc;
    irq        = q;
    returni    = r;
    exp_q.push_back({na, v, it, pp4, (v ? mem_word(ia) : 32'h0)});
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"},     {31'b0, valid},     32'd0);
    check({tag, "_interrupt"}, {31'b0, interrupt}, 32'd0);
    check({tag, "_pc_plus_4"}, pc_plus_4,          32'd0);
    check({tag, "_instr"},     instr,              32'd0);
    check({tag, "_imem_addr"}, imem_addr,          32'd0);
    check({tag, "_imem_en"},   {31'b0, imem_en},   32'd1);
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;

    // Sequential fetch from reset
    step(0, 0, 32'h0, 0, 0, 1, 0, 32'h4,  32'h0, 32'h4);
    step(0, 0, 32'h0, 0, 0, 1, 0, 32'h8,  32'h4, 32'h8);
    step(0, 0, 32'h0, 0, 0, 1, 0, 32'hC,  32'h8, 32'hC);
    step(0, 0, 32'h0, 0, 0, 1, 0, 32'h10, 32'hC, 32'h10);
    // Branch at 0x10 to 0x40: one bubble
    step(0, 1, 32'h40, 0, 0, 0, 0, 32'h14, 32'h0,  32'h40);
    step(0, 0, 32'h0,  0, 0, 1, 0, 32'h44, 32'h40, 32'h44);
    step(0, 1, 32'h1C, 0, 0, 0, 0, 32'h48, 32'h0,  32'h1C);
    step(0, 0, 32'h0,  0, 0, 1, 0, 32'h20, 32'h1C, 32'h20);
    // Stall at 0x20 for 3 cycles; last one also presents a branch (stall wins)
    for (int i = 0; i < 3; i++) begin
      step(1, (i == 2), 32'h200, 0, 0, 1, 0, 32'h20, 32'h1C, 32'h20);
      check($sformatf("imem_en_stall%0d", i), {31'b0, imem_en}, 32'd0);
    end
    step(0, 0, 32'h0, 0, 0, 1, 0, 32'h24, 32'h20, 32'h24);
    step(0, 0, 32'h0, 0, 0, 1, 0, 32'h28, 32'h24, 32'h28);
    // Wrap at the top of the address space
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'h2C, 32'h0, 32'hFFFF_FFFC);
    step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFFC, 32'h0);
    step(0, 0, 32'h0, 0, 0, 1, 0, 32'h4, 32'h0, 32'h4);
    step(0, 1, 32'h30, 0, 0, 0, 0, 32'h8, 32'h0, 32'h30);

`ifdef IF_STAGE_INT_EN
    // irq at 0x30: bubble, then ISR first instruction linked to 0x30
    step(0, 0, 32'h0, 1, 0, 0, 0, 32'h34,  32'h0,   32'h100);
    step(0, 0, 32'h0, 1, 0, 1, 1, 32'h30,  32'h100, 32'h104);
    // irq still high in ISR: masked
    step(0, 0, 32'h0, 1, 0, 1, 0, 32'h108, 32'h104, 32'h108);
    step(0, 0, 32'h0, 1, 0, 1, 0, 32'h10C, 32'h108, 32'h10C);
    step(0, 0, 32'h0, 1, 1, 1, 0, 32'h110, 32'h10C, 32'h110);
    // Back in RUN: next irq accepted
    step(0, 0, 32'h0, 1, 0, 0, 0, 32'h114, 32'h0,   32'h100);
    step(0, 0, 32'h0, 0, 0, 1, 1, 32'h110, 32'h100, 32'h104);
    step(0, 1, 32'h50, 0, 1, 0, 0, 32'h108, 32'h0,  32'h50);
    // irq with branch to 0x80: branch first, then interrupt links 0x80
    step(0, 1, 32'h80, 1, 0, 0, 0, 32'h54, 32'h0,   32'h80);
    step(0, 0, 32'h0,  1, 0, 0, 0, 32'h84, 32'h0,   32'h100);
    step(0, 0, 32'h0,  0, 0, 1, 1, 32'h80, 32'h100, 32'h104);
    // Reset while in ISR
    rst_n = 1'b0;
    #1;
    check_reset_state("reset_isr");
    release_reset();
    step(0, 0, 32'h0, 1, 0, 0, 0, 32'h4,   32'h0,   32'h100);
    step(0, 0, 32'h0, 0, 0, 1, 1, 32'h0,   32'h100, 32'h104);
    step(0, 0, 32'h0, 0, 1, 1, 0, 32'h108, 32'h104, 32'h108);
    // Branch during TAKE: branch wins, then vector is re-targeted
    step(0, 0, 32'h0,  1, 0, 0, 0, 32'h10C, 32'h0,   32'h100);
    step(0, 1, 32'h90, 0, 0, 0, 0, 32'h104, 32'h0,   32'h90);
    step(0, 0, 32'h0,  0, 0, 0, 0, 32'h94,  32'h0,   32'h100);
    step(0, 0, 32'h0,  0, 0, 1, 1, 32'h90,  32'h100, 32'h104);
    // Stall beats returni; ISR exit only when unstalled
    step(1, 0, 32'h0, 0, 1, 1, 1, 32'h90,  32'h100, 32'h104);
    step(0, 0, 32'h0, 0, 1, 1, 0, 32'h108, 32'h104, 32'h108);
    step(0, 0, 32'h0, 1, 0, 0, 0, 32'h10C, 32'h0,   32'h100);
`else
    // Interrupt support absent: irq/returni have no effect
    step(0, 0, 32'h0, 1, 0, 1, 0, 32'h34, 32'h30, 32'h34);
    step(0, 0, 32'h0, 1, 1, 1, 0, 32'h38, 32'h34, 32'h38);
    rst_n = 1'b0;
    #1;
    check_reset_state("reset_run");
    release_reset();
    step(0, 0, 32'h0, 1, 0, 1, 0, 32'h4, 32'h0, 32'h4);
    step(0, 0, 32'h0, 0, 0, 1, 0, 32'h8, 32'h4, 32'h8);
`endif

    irq = 1'b0;
    returni = 1'b0;
    check("queue_drained", exp_q.size(), 32'd0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
